board_scan_driver: RTL and testbench
====================================

BOARD_SCAN_DRIVER -- requirements
Module: board_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles per column slot, minimum 2.
REQ-002 SHALL have parameter BLINK_DIV, default 64: full frames per blink-phase toggle, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports col1..col7, input, 12 bits each: board column k, 2-bit cell per row; bits [2r+1:2r] are row r, with r=0 as the bottom row.
REQ-006 SHALL have port A, input, 3 bits: cursor column index, 0..6; values 7 and above mean no cursor.
REQ-007 SHALL have port player_colour, input, 1 bit: current player (0 red, 1 green).
REQ-008 SHALL have port win, input, 2 bits: game result (00 none, 01 red wins, 10 green wins, 11 draw).
REQ-009 SHALL have port col_en, output, 7 bits: one-hot column strobe, active-high; bit k drives board column k.
REQ-010 SHALL have port row_red, output, 7 bits: red row drive; bits 0..5 are board rows, bit 6 is the cursor row.
REQ-011 SHALL have port row_grn, output, 7 bits: green row drive, with the same bit layout as row_red.

Function
REQ-012 SHALL keep a slot counter cnt running 0..SCAN_DIV-1 and a column index k running 0..6; cnt wraps to 0 after SCAN_DIV-1, and k increments on each cnt wrap, with 6 wrapping to 0.
REQ-013 SHALL treat one frame as the seven slots k=0..6, i.e. 7*SCAN_DIV cycles.
REQ-014 SHALL, in the cycle where k=0 and cnt=0, snapshot col1..col7, A, player_colour and win into internal registers; all decoding in that frame SHALL use only the snapshot.
REQ-015 SHALL register all outputs; in each slot, the first cycle SHALL output col_en=0, row_red=0, row_grn=0 (anti-ghost blank).
REQ-016 SHALL, for the remaining SCAN_DIV-1 cycles of slot k, output col_en with only bit k set and rows decoded from snapshot column k+1.
REQ-017 SHALL decode each cell as: 00 off/off; 01 red=1, grn=0; 10 red=0, grn=1; 11 off/off (reserved code).
REQ-018 SHALL keep a frame counter running 0..BLINK_DIV-1 and toggle blink_phase when it wraps at the end of a frame.
REQ-019 SHALL, when snapshot win=00, drive cursor row bit 6 only in slot k equal to snapshot A, and only while blink_phase=0; its colour SHALL be red when player_colour=0 and green when player_colour=1.
REQ-020 SHALL, when snapshot win=00 and A>=7, drive cursor row bit 6 off in every slot.
REQ-021 SHALL, when snapshot win!=00, drive cursor row bit 6 steadily lit in every slot and ignore A.
REQ-022 SHALL, under REQ-021, use red for win=01, green for win=10, and red and green together for win=11.
REQ-023 SHALL, when snapshot win!=00, blank board rows 0..5 while blink_phase=1 and show them normally while blink_phase=0.
REQ-024 SHALL let input changes within a frame take effect only at the next frame-start snapshot.
REQ-025 SHALL drive at most one col_en bit high in any cycle.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, clear cnt, k, the frame counter, blink_phase, all snapshot registers, col_en, row_red and row_grn to 0.
REQ-027 SHALL, in the first cycle after reset deasserts, have cnt=0 and k=0 and take the frame-start snapshot.
REQ-028 SHALL, when reset is asserted mid-slot, produce all-zero outputs at the next edge; partial frames SHALL NOT be resumed.

Verification
REQ-029 SHALL cover: SCAN_DIV=4, BLINK_DIV=2, reset released -> cycle 0 blank; cycles 1-3 col_en=0000001; cycle 4 blank; cycles 5-7 col_en=0000010; cycle 28 blank; cycles 29-31 col_en=0000001 again.
REQ-030 SHALL cover: col1=12'b01_00_00_00_10_01, win=00, A=7 -> slot 0 gives row_red=0100001 with bit 6 clear and row_grn=0000010; all other slots give rows 0.
REQ-031 SHALL cover: A=3, player_colour=1, win=00, empty board -> slot 3 has row_grn bit 6 set in frames 0-1, clear in frames 2-3, set in frames 4-5; row_red stays 0 throughout.
REQ-032 SHALL cover: win=11, col4=12'h555 -> every slot has row_red[6]=row_grn[6]=1; slot 3 has row_red[5:0]=111111 in frames 0-1 and 000000 in frames 2-3.
REQ-033 SHALL cover: col2 changed mid-frame 0 -> slot 1 output stays at the old value for the rest of frame 0 and shows the new value from frame 1.
REQ-034 SHALL cover: reset pulsed during slot 4, cnt=2 -> all outputs are 0 at the next edge, and after release the scan restarts at slot 0 with blink_phase=0.

Source files
------------

// File: rtl/board_scan_driver.sv
// Multiplexed LED board scanner: 7 column slots per frame, 6 board rows plus a cursor row,
// with a once-per-frame input snapshot, an anti-ghost blank cycle and a slow blink phase.
module board_scan_driver #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] col1,
    input  logic [11:0] col2,
    input  logic [11:0] col3,
    input  logic [11:0] col4,
    input  logic [11:0] col5,
    input  logic [11:0] col6,
    input  logic [11:0] col7,
    input  logic [2:0]  A,
    input  logic        player_colour,
    input  logic [1:0]  win,
    output logic [6:0]  col_en,
    output logic [6:0]  row_red,
    output logic [6:0]  row_grn
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    k_reg, k_next;
    logic [FW-1:0] frame_reg, frame_next;
    logic          blink_reg, blink_next;

    logic [11:0]   cols_in       [7];
    logic [11:0]   snap_col_reg  [7];
    logic [11:0]   snap_col_next [7];
    logic [2:0]    snap_a_reg, snap_a_next;
    logic          snap_pc_reg, snap_pc_next;
    logic [1:0]    snap_win_reg, snap_win_next;

    logic          frame_start, slot_end, frame_end;
    logic [11:0]   col_sel;
    logic [5:0]    board_red, board_grn;
    logic          cur_red, cur_grn, hide_board;

    assign cols_in[0] = col1;
    assign cols_in[1] = col2;
    assign cols_in[2] = col3;
    assign cols_in[3] = col4;
    assign cols_in[4] = col5;
    assign cols_in[5] = col6;
    assign cols_in[6] = col7;

    assign frame_start = (cnt_reg == '0) && (k_reg == 3'd0);
    assign slot_end    = (cnt_reg == CNT_LAST);
    assign frame_end   = slot_end && (k_reg == 3'd6);

    always_comb begin
        cnt_next   = slot_end ? '0 : cnt_reg + 1'b1;
        k_next     = k_reg;
        frame_next = frame_reg;
        blink_next = blink_reg;
        if (slot_end) begin
            k_next = (k_reg == 3'd6) ? 3'd0 : k_reg + 3'd1;
        end
        if (frame_end) begin
            if (frame_reg == FRM_LAST) begin
                frame_next = '0;
                blink_next = ~blink_reg;
            end else begin
                frame_next = frame_reg + 1'b1;
            end
        end
    end

    // The snapshot is captured at the frame-start edge; decoding for the next cycle
    // must already see the freshly captured values, so it reads the _next side.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_snap
            assign snap_col_next[gi] = frame_start ? cols_in[gi] : snap_col_reg[gi];
        end
    endgenerate
    assign snap_a_next   = frame_start ? A             : snap_a_reg;
    assign snap_pc_next  = frame_start ? player_colour : snap_pc_reg;
    assign snap_win_next = frame_start ? win           : snap_win_reg;

    assign col_sel = snap_col_next[k_next];

    generate
        for (gi = 0; gi < 6; gi++) begin : g_cell
            assign board_red[gi] = (col_sel[2*gi+1:2*gi] == 2'b01);
            assign board_grn[gi] = (col_sel[2*gi+1:2*gi] == 2'b10);
        end
    endgenerate

    // k_next never exceeds 6, so an out-of-range cursor index never matches.
    always_comb begin
        cur_red = 1'b0;
        cur_grn = 1'b0;
        if (snap_win_next != 2'b00) begin
            cur_red = snap_win_next[0];
            cur_grn = snap_win_next[1];
        end else if ((snap_a_next == k_next) && !blink_reg) begin
            cur_red = ~snap_pc_next;
            cur_grn = snap_pc_next;
        end
    end

    assign hide_board = (snap_win_next != 2'b00) && blink_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            k_reg        <= 3'd0;
            frame_reg    <= '0;
            blink_reg    <= 1'b0;
            snap_a_reg   <= 3'd0;
            snap_pc_reg  <= 1'b0;
            snap_win_reg <= 2'b00;
            for (int i = 0; i < 7; i++) begin
                snap_col_reg[i] <= 12'd0;
            end
            col_en  <= 7'd0;
            row_red <= 7'd0;
            row_grn <= 7'd0;
        end else begin
            cnt_reg      <= cnt_next;
            k_reg        <= k_next;
            frame_reg    <= frame_next;
            blink_reg    <= blink_next;
            snap_a_reg   <= snap_a_next;
            snap_pc_reg  <= snap_pc_next;
            snap_win_reg <= snap_win_next;
            for (int i = 0; i < 7; i++) begin
                snap_col_reg[i] <= snap_col_next[i];
            end
            if (cnt_next == '0) begin
                col_en  <= 7'd0;
                row_red <= 7'd0;
                row_grn <= 7'd0;
            end else begin
                col_en  <= 7'(7'd1 << k_next);
                row_red <= {cur_red, hide_board ? 6'd0 : board_red};
                row_grn <= {cur_grn, hide_board ? 6'd0 : board_grn};
            end
        end
    end
endmodule

// File: tb/tb_board_scan_driver.sv
// Scoreboard bench for board_scan_driver: expected per-cycle outputs are queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_board_scan_driver;
    localparam int SD = 4;
    localparam int BD = 2;
    localparam int FL = 7 * SD;

    logic        clk;
    logic        reset;
    logic [11:0] col1, col2, col3, col4, col5, col6, col7;
    logic [2:0]  A;
    logic        player_colour;
    logic [1:0]  win;
    logic [6:0]  col_en, row_red, row_grn;

    board_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset),
        .col1(col1), .col2(col2), .col3(col3), .col4(col4),
        .col5(col5), .col6(col6), .col7(col7),
        .A(A), .player_colour(player_colour), .win(win),
        .col_en(col_en), .row_red(row_red), .row_grn(row_grn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int       cyc;
        logic [6:0] col_en;
        logic [6:0] red;
        logic [6:0] grn;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   gcyc   = 0;
    int   base   = 0;
    int   base2  = 0;
    logic ending = 1'b0;

    always @(posedge clk) gcyc <= gcyc + 1;

    // Monitor: compares whatever entry is due this cycle, independent of the stimulus.
    always @(negedge clk) begin
        checks++;
        if ($countones(col_en) > 1) begin
            errors++;
            $display("FAIL onehot cyc=%0d col_en=%b (at most one bit set required)", gcyc, col_en);
        end
        while (q.size() > 0 && q[0].cyc < gcyc) begin
            checks++;
            errors++;
            $display("FAIL missed cyc=%0d entry never compared (now %0d)", q[0].cyc, gcyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == gcyc) begin
            e = q.pop_front();
            checks++;
            if (col_en !== e.col_en || row_red !== e.red || row_grn !== e.grn) begin
                errors++;
                $display("FAIL outputs cyc=%0d got col_en=%b red=%b grn=%b required col_en=%b red=%b grn=%b",
                         gcyc, col_en, row_red, row_grn, e.col_en, e.red, e.grn);
            end
        end
        if (ending) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL leftover %0d expected entries never reached", q.size());
                q.delete();
            end
        end
    end

    task automatic push_entry(input int cy, input logic [6:0] ce, input logic [6:0] r, input logic [6:0] g);
        exp_t x;
        x.cyc = cy; x.col_en = ce; x.red = r; x.grn = g;
        q.push_back(x);
    endtask

    task automatic push_slot(input int b, input int frame, input int slot,
                             input logic [6:0] r, input logic [6:0] g, input int lim);
        for (int c = 0; c < SD; c++) begin
            int cy;
            logic [6:0] one;
            cy  = b + frame * FL + slot * SD + c;
            one = 7'd1;
            if (cy <= lim) begin
                if (c == 0) push_entry(cy, 7'd0, 7'd0, 7'd0);
                else        push_entry(cy, one << slot, r, g);
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (gcyc < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Holds reset for two edges; the period after the final reset edge is scan cycle 0.
    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        push_entry(gcyc, 7'd0, 7'd0, 7'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        base = gcyc;
    endtask

    localparam int BIG = 32'h7fff_ffff;

    initial begin
        reset = 1'b1;
        col1 = '0; col2 = '0; col3 = '0; col4 = '0; col5 = '0; col6 = '0; col7 = '0;
        A = 3'd7; player_colour = 1'b0; win = 2'b00;

        // Scan timing plus cell decode; column 3 is all reserved code and must stay dark.
        col1 = 12'b01_00_00_00_10_01;
        col3 = 12'hFFF;
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 7; s++)
                push_slot(base, f, s, (s == 0) ? 7'b0100001 : 7'd0, (s == 0) ? 7'b0000010 : 7'd0, BIG);
        wait_until(base + 2 * FL);
        $display("scenario scan/decode done at cycle %0d", gcyc);

        // Blinking green cursor on column 3.
        col1 = '0; col3 = '0;
        A = 3'd3; player_colour = 1'b1; win = 2'b00;
        do_reset();
        for (int f = 0; f < 6; f++)
            for (int s = 0; s < 7; s++)
                push_slot(base, f, s, 7'd0, (s == 3 && ((f / 2) % 2 == 0)) ? 7'h40 : 7'd0, BIG);
        wait_until(base + 6 * FL);
        $display("scenario cursor blink done at cycle %0d", gcyc);

        // Draw: steady both-colour cursor row, board rows blink.
        player_colour = 1'b0; win = 2'b11; col4 = 12'h555;
        do_reset();
        for (int f = 0; f < 4; f++)
            for (int s = 0; s < 7; s++)
                push_slot(base, f, s, 7'h40 | ((s == 3 && f < 2) ? 7'h3f : 7'h00), 7'h40, BIG);
        wait_until(base + 4 * FL);
        $display("scenario draw done at cycle %0d", gcyc);

        // Mid-frame change of column 2 only shows up in the next frame.
        win = 2'b00; A = 3'd7; col4 = '0; col2 = 12'h001;
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 7; s++)
                push_slot(base, f, s, (s == 1 && f == 0) ? 7'h01 : 7'd0,
                                      (s == 1 && f == 1) ? 7'h01 : 7'd0, BIG);
        wait_until(base + 6);
        col2 = 12'h002;
        wait_until(base + 2 * FL);
        $display("scenario snapshot hold done at cycle %0d", gcyc);

        // Reset pulse in frame 2 (blink phase 1), slot 4, cnt 2; scan restarts with phase 0.
        col2 = '0; col5 = 12'h001; win = 2'b11; A = 3'd7;
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 7; s++)
                push_slot(base, f, s, 7'h40 | ((s == 4) ? 7'h01 : 7'h00), 7'h40, BIG);
        for (int s = 0; s < 5; s++)
            push_slot(base, 2, s, 7'h40, 7'h40, base + 2 * FL + 4 * SD + 2);
        base2 = base + 2 * FL + 4 * SD + 3;
        for (int s = 0; s < 7; s++)
            push_slot(base2, 0, s, 7'h40 | ((s == 4) ? 7'h01 : 7'h00), 7'h40, BIG);
        wait_until(base + 2 * FL + 4 * SD + 2);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        wait_until(base2 + FL);
        $display("scenario mid-slot reset done at cycle %0d", gcyc);

        ending = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
